// File: rtl/i2s_rx_ctrl.sv
// I2S receive controller: generates bclk/lrclk as frame master, runs/drains frames, and pairs
// the receiver's left/right strobes into 32-bit stereo samples. Optional macro: I2S_CTRL_FRAME_CNT_EN.
module i2s_rx_ctrl #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned SLOT_BITS = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  output logic        bclk_o,
  output logic        lrclk_o,
  output logic        busy_o,
  input  logic [15:0] data_left_i,
  input  logic        strobe_left_i,
  input  logic [15:0] data_right_i,
  input  logic        strobe_right_i,
  output logic [31:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        overflow_o,
  input  logic        clr_ovf_i
`ifdef I2S_CTRL_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt_o
`endif
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [1:0]       drain_cnt_q;
  logic             bclk_q;
  logic             lrclk_q;
  logic             stop_req_q;

  logic div_wrap;
  logic fall_tick;
  logic slot_end;

  assign div_wrap  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign fall_tick = div_wrap & bclk_q;
  assign slot_end  = fall_tick & (bit_cnt_q == BIT_W'(SLOT_BITS - 1));

  // A stop request is remembered so the frame always ends after its right slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      drain_cnt_q <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      stop_req_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          div_cnt_q   <= '0;
          bit_cnt_q   <= '0;
          drain_cnt_q <= '0;
          bclk_q      <= 1'b0;
          lrclk_q     <= 1'b0;
          stop_req_q  <= 1'b0;
          if (enable_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          div_cnt_q <= div_wrap ? '0 : div_cnt_q + 1'b1;
          if (div_wrap) bclk_q <= ~bclk_q;
          if (!enable_i) stop_req_q <= 1'b1;
          if (slot_end) begin
            bit_cnt_q <= '0;
            lrclk_q   <= ~lrclk_q;
            if (lrclk_q && (stop_req_q || !enable_i)) begin
              state_q     <= ST_DRAIN;
              stop_req_q  <= 1'b0;
              drain_cnt_q <= '0;
            end
          end else if (fall_tick) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          div_cnt_q <= div_wrap ? '0 : div_cnt_q + 1'b1;
          if (div_wrap) bclk_q <= ~bclk_q;
          if (fall_tick) begin
            if (drain_cnt_q == 2'd3) begin
              state_q     <= ST_IDLE;
              div_cnt_q   <= '0;
              drain_cnt_q <= '0;
            end else begin
              drain_cnt_q <= drain_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bclk_o  = bclk_q;
  assign lrclk_o = lrclk_q;
  assign busy_o  = (state_q != ST_IDLE);

  logic [2:0]  sync_l_q;
  logic [2:0]  sync_r_q;
  logic        left_rise;
  logic        right_rise;
  logic [15:0] left_hold_q, left_hold_d;
  logic        have_left_q, have_left_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        overflow_q, overflow_d;
  logic        pair_evt;
  logic        pair_drop;
  logic        pair_load;

  // Strobes come from the bclk domain: two sync stages, the third stage only for edge detect.
  assign left_rise  = sync_l_q[1] & ~sync_l_q[2];
  assign right_rise = sync_r_q[1] & ~sync_r_q[2];

  assign pair_evt  = right_rise & have_left_q;
  assign pair_drop = pair_evt & out_valid_q & ~out_ready_i;
  assign pair_load = pair_evt & ~pair_drop;

  always_comb begin
    left_hold_d = left_hold_q;
    have_left_d = have_left_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overflow_d  = (overflow_q & ~clr_ovf_i) | pair_drop;
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    if (right_rise) have_left_d = 1'b0;
    if (pair_load) begin
      out_data_d  = {left_hold_q, data_right_i};
      out_valid_d = 1'b1;
    end
    if (left_rise) begin
      left_hold_d = data_left_i;
      have_left_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_l_q    <= '0;
      sync_r_q    <= '0;
      left_hold_q <= '0;
      have_left_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync_l_q    <= {sync_l_q[1:0], strobe_left_i};
      sync_r_q    <= {sync_r_q[1:0], strobe_right_i};
      left_hold_q <= left_hold_d;
      have_left_q <= have_left_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign overflow_o  = overflow_q;

`ifdef I2S_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_cnt_q <= '0;
    end else if (pair_load) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Self-checking bench for i2s_rx_ctrl: clock timing, pairing scoreboard, backpressure/overflow,
// stop/drain, unpaired strobes and mid-frame reset. Honours I2S_CTRL_FRAME_CNT_EN if defined.
module tb_i2s_rx_ctrl;

  localparam int CLK_DIV   = 2;
  localparam int SLOT_BITS = 16;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic        bclk;
  logic        lrclk;
  logic        busy;
  logic [15:0] dataLeft;
  logic        strobeLeft;
  logic [15:0] dataRight;
  logic        strobeRight;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;
  logic        overflow;
  logic        clrOvf;
`ifdef I2S_CTRL_FRAME_CNT_EN
  logic [15:0] frameCnt;
`endif

  int          testsRun = 0;
  int          testsFailed = 0;
  int          expFrames = 0;
  logic [31:0] sbQueue[$];

  i2s_rx_ctrl #(
    .CLK_DIV  (CLK_DIV),
    .SLOT_BITS(SLOT_BITS)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .enable_i      (enable),
    .bclk_o        (bclk),
    .lrclk_o       (lrclk),
    .busy_o        (busy),
    .data_left_i   (dataLeft),
    .strobe_left_i (strobeLeft),
    .data_right_i  (dataRight),
    .strobe_right_i(strobeRight),
    .out_data_o    (outData),
    .out_valid_o   (outValid),
    .out_ready_i   (outReady),
    .overflow_o    (overflow),
    .clr_ovf_i     (clrOvf)
`ifdef I2S_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt_o   (frameCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit isRight, input logic [15:0] data);
    if (isRight) begin
      dataRight   = data;
      strobeRight = 1'b1;
    end else begin
      dataLeft   = data;
      strobeLeft = 1'b1;
    end
    repeat (2) tick();
    strobeLeft  = 1'b0;
    strobeRight = 1'b0;
    repeat (4) tick();
  endtask

  task automatic checkFrameCnt(input string tag);
`ifdef I2S_CTRL_FRAME_CNT_EN
    checkOutput(tag, {16'b0, frameCnt}, 32'(expFrames));
`else
    if (tag.len() == 0) $display("[TB] empty tag");
`endif
  endtask

  // Cycle k is the k-th rising edge after RUN entry; bclk/lrclk follow closed-form expectations.
  task automatic checkClockRun(input int nCycles);
    for (int k = 1; k <= nCycles; k++) begin
      tick();
      checkOutput("run_busy", {31'b0, busy}, 32'd1);
      checkOutput("run_bclk", {31'b0, bclk}, 32'(((k - 1) / CLK_DIV) % 2));
      checkOutput("run_lrclk", {31'b0, lrclk}, 32'(((k - 1) / (SLOT_BITS * 2 * CLK_DIV)) % 2));
    end
  endtask

  task automatic waitLrclk(input logic level, input int limit);
    int n = 0;
    while (lrclk !== level && n < limit) begin
      tick();
      n++;
    end
    checkOutput("wait_lrclk", {31'b0, lrclk}, {31'b0, level});
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_bclk"}, {31'b0, bclk}, 32'd0);
    checkOutput({tag, "_lrclk"}, {31'b0, lrclk}, 32'd0);
    checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({tag, "_valid"}, {31'b0, outValid}, 32'd0);
    checkOutput({tag, "_ovf"}, {31'b0, overflow}, 32'd0);
    checkOutput({tag, "_data"}, outData, 32'd0);
    checkFrameCnt({tag, "_fcnt"});
  endtask

  // Scoreboard consumer: a transfer happens at the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rstN && outValid && outReady) begin
      if (sbQueue.size() == 0) begin
        checkOutput("xfer_unexpected", {31'b0, outValid & outReady}, 32'd0);
      end else begin
        checkOutput("xfer_data", outData, sbQueue.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drainCycles;
    rstN        = 1'b0;
    enable      = 1'b1;
    dataLeft    = '0;
    strobeLeft  = 1'b0;
    dataRight   = '0;
    strobeRight = 1'b0;
    outReady    = 1'b1;
    clrOvf      = 1'b0;

    repeat (3) tick();
    checkResetValues("reset");

    rstN = 1'b1;
    checkClockRun(260);

    applyStimulus(1'b0, 16'h1234);
    sbQueue.push_back(32'h1234ABCD);
    expFrames++;
    dataRight   = 16'hABCD;
    strobeRight = 1'b1;
    tick();
    checkOutput("pair_lat1", {31'b0, outValid}, 32'd0);
    tick();
    checkOutput("pair_lat2", {31'b0, outValid}, 32'd0);
    tick();
    checkOutput("pair_valid", {31'b0, outValid}, 32'd1);
    checkOutput("pair_data", outData, 32'h1234ABCD);
    strobeRight = 1'b0;
    tick();
    checkOutput("pair_one_cycle", {31'b0, outValid}, 32'd0);
    checkFrameCnt("pair_fcnt");
    repeat (4) tick();

    outReady = 1'b0;
    applyStimulus(1'b0, 16'h0001);
    sbQueue.push_back(32'h00010002);
    expFrames++;
    applyStimulus(1'b1, 16'h0002);
    applyStimulus(1'b0, 16'h0003);
    applyStimulus(1'b1, 16'h0004);
    checkOutput("bp_valid", {31'b0, outValid}, 32'd1);
    checkOutput("bp_hold", outData, 32'h00010002);
    checkOutput("bp_ovf", {31'b0, overflow}, 32'd1);
    checkFrameCnt("bp_fcnt");
    clrOvf = 1'b1;
    tick();
    clrOvf = 1'b0;
    checkOutput("bp_ovf_clr", {31'b0, overflow}, 32'd0);
    checkOutput("bp_hold2", outData, 32'h00010002);
    outReady = 1'b1;
    tick();
    checkOutput("bp_drained", {31'b0, outValid}, 32'd0);
    checkOutput("bp_sb_empty", 32'(sbQueue.size()), 32'd0);

    waitLrclk(1'b1, 200);
    waitLrclk(1'b0, 200);
    repeat (20) tick();
    enable = 1'b0;
    waitLrclk(1'b1, 200);
    waitLrclk(1'b0, 200);
    checkOutput("stop_fall_bclk", {31'b0, bclk}, 32'd0);
    checkOutput("stop_fall_busy", {31'b0, busy}, 32'd1);
    drainCycles = 0;
    while (busy && drainCycles < 100) begin
      tick();
      drainCycles++;
      if (drainCycles == 5) enable = 1'b1;
      if (drainCycles == 6) enable = 1'b0;
    end
    checkOutput("drain_len", 32'(drainCycles), 32'(4 * 2 * CLK_DIV));
    checkOutput("stop_bclk", {31'b0, bclk}, 32'd0);
    checkOutput("stop_lrclk", {31'b0, lrclk}, 32'd0);
    repeat (10) tick();
    checkOutput("stop_stays_idle", {31'b0, busy}, 32'd0);

    applyStimulus(1'b1, 16'h5555);
    checkOutput("unpaired_valid", {31'b0, outValid}, 32'd0);
    checkOutput("unpaired_ovf", {31'b0, overflow}, 32'd0);

    enable   = 1'b1;
    outReady = 1'b0;
    applyStimulus(1'b0, 16'h1111);
    expFrames++;
    applyStimulus(1'b1, 16'h2222);
    applyStimulus(1'b0, 16'h3333);
    applyStimulus(1'b1, 16'h4444);
    checkOutput("pre_rst_data", outData, 32'h11112222);
    checkOutput("pre_rst_ovf", {31'b0, overflow}, 32'd1);
    checkFrameCnt("pre_rst_fcnt");
    applyStimulus(1'b0, 16'h7777);
    waitLrclk(1'b1, 200);
    repeat (50) tick();
    #2;
    rstN = 1'b0;
    #1;
    expFrames = 0;
    checkResetValues("midrst");
    tick();
    tick();
    outReady = 1'b1;
    rstN     = 1'b1;
    checkClockRun(140);

    applyStimulus(1'b1, 16'h8888);
    checkOutput("lost_partial_valid", {31'b0, outValid}, 32'd0);
    checkOutput("lost_partial_ovf", {31'b0, overflow}, 32'd0);
    checkFrameCnt("final_fcnt");
    checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/i2s_rx_ctrl.md
# i2s_rx_ctrl

Clock/frame master and sample sequencer for the `mod_i2s` receiver. It divides the system clock to produce `bclk`/`lrclk`, starts and stops frames cleanly, and captures the receiver's left/right strobes. It pairs them into stereo samples and presents each pair on a valid/ready stream with sticky overflow detection. It sits between the I2S pins/receiver (bclk domain) and the system-clock sample consumer.

## Interface
- `CLK_DIV`, 2: system clocks per bclk half-period; legal values ≥2.
- `SLOT_BITS`, 16: bclk periods per lrclk half (channel slot).
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; 1 = run frames, 0 = stop at the next frame boundary.
- `bclk` out 1: generated bit clock, registered.
- `lrclk` out 1: generated word clock, registered; 0 = left slot, 1 = right slot.
- `busy` out 1: state ≠ IDLE.
- `data_left` in 16: from receiver.
- `strobe_left` in 1: from receiver, bclk domain.
- `data_right` in 16: from receiver.
- `strobe_right` in 1: from receiver, bclk domain.
- `out_data` out 32: {left[15:0], right[15:0]}.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready.
- `overflow` out 1: sticky; a pair was dropped.
- `clr_ovf` in 1: 1-cycle pulse; clears `overflow`.
- `frame_cnt` out 16: present only with `I2S_CTRL_FRAME_CNT_EN`.

## Operation
- Reset values: `bclk`=0, `lrclk`=0, `busy`=0, `out_data`=0, `out_valid`=0, `overflow`=0, `frame_cnt`=0. Internal state is IDLE, with the divider, bit counter and have_left all cleared.
- **Divider:** `div_cnt` counts 0..CLK_DIV-1. On wrap, `bclk` toggles. It runs only in RUN and DRAIN, and holds 0 in IDLE.
- **Bit counter:** increments on each bclk falling toggle. On a falling toggle with `bit_cnt`==SLOT_BITS-1, `lrclk` toggles and `bit_cnt`←0.
- **FSM:**
  - IDLE: `bclk`=0, `lrclk`=0. `enable`=1 → RUN next cycle, with `lrclk`=0 and counters at 0.
  - RUN: free-running frames. If `enable`=0 is sampled at any point, the block completes the current frame. At the right-slot end (`lrclk` 1→0 toggle) it goes to DRAIN instead of starting a new left slot; the toggle still occurs.
  - DRAIN: keeps clocking `bclk` for 4 more periods so the receiver can register its right trigger. Then IDLE, with `bclk`=0 and `lrclk`=0. `enable` is ignored in DRAIN.
- **Strobe capture:**
  - `strobe_left` and `strobe_right` each pass through a 2-FF synchronizer and a rising-edge detect.
  - Data buses are sampled on the detect cycle. They are stable because the receiver holds them for a full slot.
- **Pairing:**
  - Left edge: `left_hold`←`data_left` and have_left←1. A second left event overwrites `left_hold`.
  - Right edge with have_left=0: discarded.
  - Right edge with have_left=1:
    - If `out_valid`=1 and `out_ready`=0, set `overflow` and drop the pair. `out_data` is unchanged and have_left←0.
    - Otherwise, `out_data`←{left_hold, data_right}, `out_valid`←1, have_left←0.
- **Stream handshake:**
  - Transfer occurs when `out_valid`&`out_ready`.
  - After a transfer with no new pair, `out_valid`←0.
  - A transfer and a new pair in the same cycle load the new pair, and `out_valid` stays 1.
  - `out_data` must not change while `out_valid`=1 and `out_ready`=0.
- **Overflow clear:** `clr_ovf` and a new overflow in the same cycle leave `overflow`=1.

## Timing
- bclk period = 2·CLK_DIV clk.
- Slot = SLOT_BITS·2·CLK_DIV clk; frame = twice that.
- First `bclk` rise occurs CLK_DIV clk after entering RUN.
- `lrclk` changes only on the cycle `bclk` falls.
- Strobe input rise → `out_valid` high: 3 clk (2 sync + 1 register).
- Stop latency: from `enable`=0 to `busy`=0 is at most 1 frame + 4 bclk periods + 1 clk.
- An async `rst_n` assertion mid-frame forces reset values immediately. A partial pair is lost.

## Configuration
- `I2S_CTRL_FRAME_CNT_EN` defined:
  - `frame_cnt` port exists.
  - It increments by 1 on each pair loaded into `out_data`; dropped pairs are not counted.
  - It wraps 0xFFFF→0x0000 and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Clock generation:** CLK_DIV=2, SLOT_BITS=16, `enable`=1 from reset release. Required: first `bclk` rise 2 clk after RUN entry, `bclk` period 4 clk, `lrclk` rise at 64 clk, fall at 128 clk, repeating.
- **Pairing:** strobe_left with data_left=0x1234, then strobe_right with data_right=0xABCD, `out_ready`=1. Required: `out_data`=0x1234ABCD, `out_valid` for 1 cycle, 3 clk after the right strobe edge; `frame_cnt`=1 with the macro.
- **Backpressure/overflow:** `out_ready`=0, two complete pairs (0x00010002, then 0x00030004). Required: `out_data` holds 0x00010002 and `overflow`=1. Then `clr_ovf` → `overflow`=0, and `out_ready`=1 → one transfer of 0x00010002.
- **Stop:** `enable` dropped mid left slot. Required: right slot completes, `lrclk` falls, 4 more bclk periods, then `busy`=0 with `bclk`=0 and `lrclk`=0. `enable` pulsed during DRAIN has no effect.
- **Unpaired right:** strobe_right with no prior left. Required: `out_valid` stays 0 and `overflow` stays 0.
- **Reset mid-frame:** `rst_n` low at clk 50 of a slot. Required: all outputs at reset values within the same cycle. On release with `enable`=1, timing restarts per the clock-generation test.
